dac_i2s_serializer: RTL and testbench

//  Parametrised stereo DAC serializer for the WM8731 playback path. Buffers
//  {left,right} sample frames in a small FIFO behind a valid/ready handshake and

---
 rtl/dac_i2s_serializer.sv | 102 ++++++++++
 tb/tb_dac_i2s_serializer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dac_i2s_serializer.sv
// dac_i2s_serializer: buffers stereo frames and shifts them MSB-first onto DACDAT, slaved to codec BCLK/LRCK
//  i_BCLK          bit clock, all logic on posedge
//  i_rst_n         async active-low reset
//  i_DACLRCK       codec LR clock, 0=left slot, 1=right slot
//  i_play          1: consume frames, 0: transmit silence
//  i_mono          1: right slot repeats the left sample
//  i_valid/o_ready frame handshake for i_data_l/i_data_r
//  o_DACDAT        registered serial data to codec
//  o_level         frames held in the FIFO
//  o_underrun      one-cycle pulse when a left slot starts with nothing to play
//  o_underrun_cnt  saturating underrun count when DAC_UNDERRUN_CNT_EN is defined, else 0
module dac_i2s_serializer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int I2S_DELAY  = 1
) (
  input  logic                          i_BCLK,
  input  logic                          i_rst_n,
  input  logic                          i_DACLRCK,
  input  logic                          i_play,
  input  logic                          i_mono,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DATA_W-1:0]             i_data_l,
  input  logic [DATA_W-1:0]             i_data_r,
  output logic                          o_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underrun,
  output logic [15:0]                   o_underrun_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_SHIFT, S_PAD} state_t;
  state_t state_q, state_d;
  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [2*DATA_W-1:0] head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] shadow_l, shadow_r, sreg;
  logic [CW-1:0] bit_cnt;
  logic lrck_q, fall, rise, full, empty, push, pop, restart, last_bit;
  assign fall     = lrck_q & ~i_DACLRCK;
  assign rise     = ~lrck_q & i_DACLRCK;
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign o_ready  = ~full;
  assign o_level  = wr_ptr - rd_ptr;
  assign push     = i_valid & ~full;
  // empty comes from registered pointers, so a same-cycle push never feeds this pop
  assign pop      = fall & i_play & ~empty;
  assign head     = mem[rd_ptr[AW-1:0]];
  // a rise before the first fall is ignored so playback always opens on the left slot
  assign restart  = fall | (rise & (state_q != S_IDLE));
  assign last_bit = bit_cnt == CW'(DATA_W-1);
  always_comb begin
    state_d = restart ? (I2S_DELAY != 0 ? S_DELAY : S_SHIFT)
            : state_q == S_DELAY ? S_SHIFT
            : (state_q == S_SHIFT && last_bit) ? S_PAD
            : state_q;
  end
  always_ff @(posedge i_BCLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {i_data_l, i_data_r};
  end
  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrck_q     <= 1'b0;
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      shadow_l   <= '0;
      shadow_r   <= '0;
      sreg       <= '0;
      bit_cnt    <= '0;
      o_DACDAT   <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      lrck_q     <= i_DACLRCK;
      state_q    <= state_d;
      o_underrun <= fall & i_play & empty;
      o_DACDAT   <= (!restart && state_q == S_SHIFT) ? sreg[DATA_W-1] : 1'b0;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (fall) begin
        shadow_l <= pop ? head[2*DATA_W-1:DATA_W] : '0;
        shadow_r <= pop ? head[DATA_W-1:0] : '0;
      end
      if (fall) sreg <= pop ? head[2*DATA_W-1:DATA_W] : '0;
      else if (restart) sreg <= i_mono ? shadow_l : shadow_r;
      else if (state_q == S_SHIFT) sreg <= {sreg[DATA_W-2:0], 1'b0};
      bit_cnt <= restart ? '0 : (state_q == S_SHIFT) ? bit_cnt + CW'(1) : bit_cnt;
    end
  end
`ifdef DAC_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt;
  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) ur_cnt <= '0;
    else if (o_underrun && ur_cnt != 16'hFFFF) ur_cnt <= ur_cnt + 16'd1;
  end
  assign o_underrun_cnt = ur_cnt;
`else
  assign o_underrun_cnt = '0;
`endif
endmodule

// File: tb/tb_dac_i2s_serializer.sv
// tb_dac_i2s_serializer: directed checks of the I2S and left-justified serializer builds side by side
module tb_dac_i2s_serializer;
  logic bclk = 1'b0, rst_n = 1'b0, lrck = 1'b0, play = 1'b1, mono = 1'b0, valid = 1'b0;
  logic [15:0] data_l = '0, data_r = '0;
  logic ready1, dat1, ur1, ready0, dat0, ur0;
  logic [2:0] level1, level0;
  logic [15:0] cnt1, cnt0;
  int checks = 0, fails = 0;
  always #5 bclk = ~bclk;
  dac_i2s_serializer #(.DATA_W(16), .FIFO_DEPTH(4), .I2S_DELAY(1)) u1 (
    .i_BCLK(bclk), .i_rst_n(rst_n), .i_DACLRCK(lrck), .i_play(play), .i_mono(mono),
    .i_valid(valid), .o_ready(ready1), .i_data_l(data_l), .i_data_r(data_r),
    .o_DACDAT(dat1), .o_level(level1), .o_underrun(ur1), .o_underrun_cnt(cnt1));
  dac_i2s_serializer #(.DATA_W(16), .FIFO_DEPTH(4), .I2S_DELAY(0)) u0 (
    .i_BCLK(bclk), .i_rst_n(rst_n), .i_DACLRCK(lrck), .i_play(play), .i_mono(mono),
    .i_valid(valid), .o_ready(ready0), .i_data_l(data_l), .i_data_r(data_r),
    .o_DACDAT(dat0), .o_level(level0), .o_underrun(ur0), .o_underrun_cnt(cnt0));
  function automatic logic [63:0] exp_seq(input logic [15:0] d, input int dl, input int n);
    logic [63:0] s;
    s = '0;
    for (int k = 1; k <= n; k++)
      s = {s[62:0], (k >= 2 + dl && k <= 17 + dl) ? d[15 - (k - 2 - dl)] : 1'b0};
    return s;
  endfunction
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge bclk);
      #1;
    end
  endtask
  task automatic push(input logic [15:0] l, input logic [15:0] r);
    valid = 1'b1;
    data_l = l;
    data_r = r;
    tick(1);
    valid = 1'b0;
  endtask
  task automatic run_slot(input logic lvl, input int n, output logic [63:0] s1, output logic [63:0] s0, output int ur);
    lrck = lvl;
    s1 = '0;
    s0 = '0;
    ur = 0;
    for (int k = 1; k <= n; k++) begin
      tick(1);
      s1 = {s1[62:0], dat1};
      s0 = {s0[62:0], dat0};
      ur += int'(ur1);
    end
  endtask
  task automatic chk_seq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic test_reset;
    logic [63:0] s1, s0;
    int ur;
    tick(3);
    checks++; if (dat1 !== 1'b0) begin fails++; $display("FAIL reset_dacdat: got %b expected 0", dat1); end
    checks++; if (ready1 !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready1); end
    checks++; if (level1 !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level1); end
    checks++; if (ur1 !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b expected 0", ur1); end
    checks++; if (cnt1 !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", cnt1); end
    rst_n = 1'b1;
    lrck = 1'b1;
    tick(2);
    push(16'hA5C3, 16'h0F0F);
    push(16'h1111, 16'h2222);
    run_slot(1'b0, 3, s1, s0, ur);
    checks++; if (s1[0] !== 1'b1) begin fails++; $display("FAIL midshift_msb: got %b expected 1", s1[0]); end
    checks++; if (level1 !== 3'd1) begin fails++; $display("FAIL midshift_level: got %0d expected 1", level1); end
    rst_n = 1'b0;
    #1;
    checks++; if (dat1 !== 1'b0) begin fails++; $display("FAIL abort_dacdat: got %b expected 0", dat1); end
    checks++; if (level1 !== 3'd0) begin fails++; $display("FAIL abort_level: got %0d expected 0", level1); end
    checks++; if (ready1 !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b expected 1", ready1); end
    tick(2);
    rst_n = 1'b1;
    lrck = 1'b1;
    run_slot(1'b1, 20, s1, s0, ur);
    chk_seq("idle_rise_ignored", s1, 64'd0);
  endtask
  task automatic test_stereo;
    logic [63:0] s1, s0;
    int ur;
    push(16'hA5C3, 16'h0F0F);
    run_slot(1'b0, 32, s1, s0, ur);
    chk_seq("stereo_left_i2s", s1, exp_seq(16'hA5C3, 1, 32));
    chk_seq("stereo_left_lj", s0, exp_seq(16'hA5C3, 0, 32));
    run_slot(1'b1, 32, s1, s0, ur);
    chk_seq("stereo_right_i2s", s1, exp_seq(16'h0F0F, 1, 32));
    chk_seq("stereo_right_lj", s0, exp_seq(16'h0F0F, 0, 32));
  endtask
  task automatic test_mono;
    logic [63:0] s1, s0;
    int ur;
    mono = 1'b1;
    push(16'h8001, 16'h7FFF);
    run_slot(1'b0, 32, s1, s0, ur);
    chk_seq("mono_left_lj", s0, exp_seq(16'h8001, 0, 32));
    run_slot(1'b1, 32, s1, s0, ur);
    chk_seq("mono_right_lj", s0, exp_seq(16'h8001, 0, 32));
    chk_seq("mono_right_i2s", s1, exp_seq(16'h8001, 1, 32));
    mono = 1'b0;
  endtask
  task automatic test_fifo_full;
    logic [63:0] s1, s0;
    logic [15:0] lv [4];
    int ur;
    lv = '{16'h1357, 16'h2468, 16'h9ABC, 16'hFEDC};
    for (int i = 0; i < 4; i++) push(lv[i], ~lv[i]);
    checks++; if (level1 !== 3'd4) begin fails++; $display("FAIL full_level: got %0d expected 4", level1); end
    checks++; if (ready1 !== 1'b0) begin fails++; $display("FAIL full_ready: got %b expected 0", ready1); end
    push(16'hDEAD, 16'hBEEF);
    checks++; if (level1 !== 3'd4) begin fails++; $display("FAIL overflow_level: got %0d expected 4", level1); end
    run_slot(1'b0, 32, s1, s0, ur);
    chk_seq("full_pop0", s1, exp_seq(lv[0], 1, 32));
    checks++; if (level1 !== 3'd3) begin fails++; $display("FAIL pop_level: got %0d expected 3", level1); end
    checks++; if (ready1 !== 1'b1) begin fails++; $display("FAIL pop_ready: got %b expected 1", ready1); end
    for (int i = 1; i < 4; i++) begin
      run_slot(1'b1, 32, s1, s0, ur);
      chk_seq("drain_right", s1, exp_seq(~lv[i-1], 1, 32));
      run_slot(1'b0, 32, s1, s0, ur);
      chk_seq("drain_left", s1, exp_seq(lv[i], 1, 32));
    end
    checks++; if (level1 !== 3'd0) begin fails++; $display("FAIL drain_level: got %0d expected 0", level1); end
  endtask
  task automatic test_underrun;
    logic [63:0] s1, s0;
    int ur, total;
    total = 0;
    for (int i = 0; i < 3; i++) begin
      run_slot(1'b1, 20, s1, s0, ur);
      total += ur;
      run_slot(1'b0, 20, s1, s0, ur);
      total += ur;
      chk_seq("underrun_zeros", s1, 64'd0);
    end
    checks++; if (total != 3) begin fails++; $display("FAIL underrun_pulses: got %0d expected 3", total); end
`ifdef DAC_UNDERRUN_CNT_EN
    checks++; if (cnt1 !== 16'd3) begin fails++; $display("FAIL underrun_cnt: got %0d expected 3", cnt1); end
`else
    checks++; if (cnt1 !== 16'd0) begin fails++; $display("FAIL underrun_cnt: got %0d expected 0", cnt1); end
`endif
    play = 1'b0;
    total = 0;
    for (int i = 0; i < 2; i++) begin
      run_slot(1'b1, 20, s1, s0, ur);
      total += ur;
      run_slot(1'b0, 20, s1, s0, ur);
      total += ur;
    end
    checks++; if (total != 0) begin fails++; $display("FAIL stopped_pulses: got %0d expected 0", total); end
    play = 1'b1;
  endtask
  task automatic test_truncate;
    logic [63:0] s1, s0;
    logic [15:0] lv [3], rv [3];
    int ur;
    lv = '{16'hA5C3, 16'h3C5A, 16'hF0F0};
    rv = '{16'h1234, 16'h8765, 16'h0FF0};
    for (int i = 0; i < 3; i++) push(lv[i], rv[i]);
    run_slot(1'b1, 10, s1, s0, ur);
    for (int i = 0; i < 3; i++) begin
      run_slot(1'b0, 10, s1, s0, ur);
      chk_seq("trunc_left_i2s", s1, exp_seq(lv[i], 1, 10));
      chk_seq("trunc_left_lj", s0, exp_seq(lv[i], 0, 10));
      checks++;
      if (level1 !== 3'(2 - i)) begin fails++; $display("FAIL trunc_level: got %0d expected %0d", level1, 2 - i); end
      run_slot(1'b1, 10, s1, s0, ur);
      chk_seq("trunc_right_i2s", s1, exp_seq(rv[i], 1, 10));
    end
  endtask
  initial begin
    test_reset;
    test_stereo;
    test_mono;
    test_fifo_full;
    test_underrun;
    test_truncate;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
